// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling UART receiver, start/DATA_BITS LSB-first/stop, no parity
module uart_rx_oversample #(
  parameter int TICKS_PER_BIT = 16,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rx_s;
  logic [TW-1:0]        r_tcnt, w_tcnt_nxt;
  logic [BW-1:0]        r_bcnt, w_bcnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_fin, w_fin_nxt;
  logic                 r_stop_s, w_stop_s_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tcnt   <= '0;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_fin    <= 1'b0;
      r_stop_s <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_fin    <= w_fin_nxt;
      r_stop_s <= w_stop_s_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tcnt_nxt   = r_tcnt;
    w_bcnt_nxt   = r_bcnt;
    w_shift_nxt  = r_shift;
    w_fin_nxt    = 1'b0;
    w_stop_s_nxt = r_stop_s;
    case (r_state)
      S_IDLE: begin
        w_tcnt_nxt = '0;
        w_bcnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (i_tick) begin
          if (r_tcnt == TICK_MID) begin
            // A line that is high again at mid-start was only a glitch.
            w_tcnt_nxt  = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (r_tcnt == TICK_END) begin
            w_tcnt_nxt  = '0;
            w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bcnt == BIT_END) begin
              w_bcnt_nxt  = '0;
              w_state_nxt = S_STOP;
            end else begin
              w_bcnt_nxt = r_bcnt + 1'b1;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (i_tick) begin
          if (r_tcnt == TICK_END) begin
            w_tcnt_nxt   = '0;
            w_stop_s_nxt = r_rx_s;
            w_fin_nxt    = 1'b1;
            w_state_nxt  = S_IDLE;
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result is published one clk after the stop sample and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data      <= '0;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_done <= r_fin;
      if (r_fin) begin
        o_data      <= r_shift;
        o_frame_err <= ~r_stop_s;
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - randomized frame bench with a frame-level expectation queue
module tb_uart_rx_oversample;

  logic       clk;
  logic       rst;
  logic       i_tick;
  logic       rx;
  logic [7:0] o_data;
  logic       o_done;
  logic       o_frame_err;
  logic       o_busy;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] last_data;
  logic       last_err;
  logic       prev_done;

  uart_rx_oversample #(.TICKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .rx          (rx),
    .o_data      (o_data),
    .o_done      (o_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick strobe with random spacing; the receiver only counts strobes.
  initial begin
    i_tick = 1'b0;
    forever begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (i_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    wait_ticks(n);
  endtask

  // Error frames release the line early so the receiver only sees a rejected start.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back({~stop, d});
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d[i], 16);
    if (stop) begin
      drive(1'b1, 16);
    end else begin
      drive(1'b0, 10);
      drive(1'b1, 26);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", {28'd0, o_done, o_busy, o_frame_err, |o_data}, 32'd0);
        last_data = 8'h00;
        last_err  = 1'b0;
        prev_done = 1'b0;
      end else if (o_done) begin
        n_done++;
        check("done_width", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("frame_data", {24'd0, o_data}, {24'd0, e[7:0]});
          check("frame_err", {31'd0, o_frame_err}, {31'd0, e[8]});
        end
        last_data = o_data;
        last_err  = o_frame_err;
        prev_done = 1'b1;
      end else begin
        check("hold_data", {24'd0, o_data}, {24'd0, last_data});
        check("hold_err", {31'd0, o_frame_err}, {31'd0, last_err});
        prev_done = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       s;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_data", {24'd0, o_data}, 32'd0);
    rst = 1'b0;
    wait_ticks(20);

    send_frame(8'h55, 1'b1);
    check("f55_data", {24'd0, o_data}, 32'h55);
    check("f55_err", {31'd0, o_frame_err}, 32'd0);
    check("f55_count", n_done, 1);
    check("f55_idle", {31'd0, o_busy}, 32'd0);

    send_frame(8'hA3, 1'b1);
    check("fa3_data", {24'd0, o_data}, 32'hA3);
    send_frame(8'hFF, 1'b1);
    check("fff_data", {24'd0, o_data}, 32'hFF);
    check("b2b_count", n_done, 3);
    wait_ticks(10);

    rx = 1'b0;
    wait_ticks(2);
    check("glitch_busy", {31'd0, o_busy}, 32'd1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(8);
    check("glitch_idle", {31'd0, o_busy}, 32'd0);
    check("glitch_count", n_done, 3);

    send_frame(8'h3C, 1'b0);
    check("f3c_bad_data", {24'd0, o_data}, 32'h3C);
    check("f3c_bad_err", {31'd0, o_frame_err}, 32'd1);
    send_frame(8'h3C, 1'b1);
    check("f3c_ok_err", {31'd0, o_frame_err}, 32'd0);
    check("f3c_count", n_done, 5);

    exp_q.push_back(9'h081);
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'(8'h81 >> i), 16);
    drive(1'b0, 8);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {28'd0, o_done, o_busy, o_frame_err, |o_data}, 32'd0);
    exp_q.delete();
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(20);
    check("midrst_count", n_done, 5);
    send_frame(8'h81, 1'b1);
    check("f81_data", {24'd0, o_data}, 32'h81);
    check("f81_count", n_done, 6);

    // Held break: two full zero frames, the third start is released before mid-start.
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h100);
    rx = 1'b0;
    wait_ticks(308);
    rx = 1'b1;
    wait_ticks(30);
    check("break_count", n_done, 8);
    check("break_data", {24'd0, o_data}, 32'h00);
    check("break_err", {31'd0, o_frame_err}, 32'd1);
    check("break_idle", {31'd0, o_busy}, 32'd0);

    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, s);
      if ($urandom_range(0, 1) == 1) drive(1'b1, $urandom_range(1, 20));
    end
    wait_ticks(20);

    check("missing_done", exp_q.size(), 0);
    check("total_done", n_done, 20);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
